// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour HH:MM:SS clock with one HH:MM alarm.
//   clk, reset          : system clock (nominally CLK_DIV Hz), async active-high reset
//   H_in1/H_in0/M_in1/M_in0 : BCD switch inputs for time or alarm loads
//   LD_time, LD_alarm   : load current time / alarm time from the switches
//   STOP_al, AL_ON      : silence the alarm / alarm enable
//   Alarm               : sticky registered alarm flag
//   H_out*/M_out*/S_out*: current time as BCD digits (combinational from counters)
// Reset loads the switch time (seconds zero), so reset doubles as a time set.
module alarm_clock #(
  parameter int CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_time,
  input  logic       LD_alarm,
  input  logic       STOP_al,
  input  logic       AL_ON,
  output logic       Alarm,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Switch values are converted without range checks; hour up to 45 and
  // minute up to 165 are representable so bad loads are kept as-is and
  // recover through the >= compares on the next carry.
  logic [5:0] hour_in;
  logic [7:0] min_in;

  logic [5:0]       hour_q, hour_d;
  logic [7:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       al_hour_q, al_hour_d;
  logic [7:0]       al_min_q, al_min_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             alarm_q, alarm_d;
  logic             tick;
  logic             al_match;

  assign hour_in = 6'(H_in1) * 6'd10 + 6'(H_in0);
  assign min_in  = 8'(M_in1) * 8'd10 + 8'(M_in0);

  assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
  assign al_match = (hour_q == al_hour_q) && (min_q == al_min_q) && (sec_q == 6'd0);

  always_comb begin
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    div_d     = div_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    alarm_d   = alarm_q;

    if (LD_time) begin
      hour_d = hour_in;
      min_d  = min_in;
      sec_d  = 6'd0;
      div_d  = '0;
    end else if (tick) begin
      div_d = '0;
      if (sec_q >= 6'd59) begin
        sec_d = 6'd0;
        if (min_q >= 8'd59) begin
          min_d  = 8'd0;
          hour_d = (hour_q >= 6'd23) ? 6'd0 : hour_q + 6'd1;
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (LD_alarm) begin
      al_hour_d = hour_in;
      al_min_d  = min_in;
    end

    // Clear beats set; otherwise the flag latches until cleared.
    if (STOP_al || !AL_ON) alarm_d = 1'b0;
    else if (al_match)     alarm_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_q    <= hour_in;
      min_q     <= min_in;
      sec_q     <= 6'd0;
      div_q     <= '0;
      al_hour_q <= 6'd0;
      al_min_q  <= 8'd0;
      alarm_q   <= 1'b0;
    end else begin
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      div_q     <= div_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      alarm_q   <= alarm_d;
    end
  end

  assign Alarm  = alarm_q;
  assign H_out1 = 2'(hour_q / 6'd10);
  assign H_out0 = 4'(hour_q % 6'd10);
  assign M_out1 = 4'(min_q / 8'd10);
  assign M_out0 = 4'(min_q % 8'd10);
  assign S_out1 = 4'(sec_q / 6'd10);
  assign S_out0 = 4'(sec_q % 6'd10);

endmodule

// File: tb/tb_alarm_clock.sv
module tb_alarm_clock;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON;
  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  int n_chk = 0;
  int n_err = 0;

  alarm_clock #(.CLK_DIV(10)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .Alarm(Alarm),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Compare all six displayed digits against HHMMSS packed as decimal digits.
  task automatic chk_time(input string tag, input int h1, input int h0, input int m1,
                          input int m0, input int s1, input int s0);
    chk({tag, ".H1"}, 32'(H_out1), 32'(h1));
    chk({tag, ".H0"}, 32'(H_out0), 32'(h0));
    chk({tag, ".M1"}, 32'(M_out1), 32'(m1));
    chk({tag, ".M0"}, 32'(M_out0), 32'(m0));
    chk({tag, ".S1"}, 32'(S_out1), 32'(s1));
    chk({tag, ".S0"}, 32'(S_out0), 32'(s0));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] h1, input logic [3:0] h0,
                        input logic [3:0] m1, input logic [3:0] m0);
    H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
  endtask

  initial begin
    reset = 1'b1; LD_time = 0; LD_alarm = 0; STOP_al = 0; AL_ON = 0;
    set_in(2'd1, 4'd0, 4'd1, 4'd9);
    #1;
    chk_time("rst", 1, 0, 1, 9, 0, 0);
    chk("rst.alarm", 32'(Alarm), 0);

    // First second arrives exactly 10 edges after release.
    tick(2);
    reset = 1'b0;
    tick(9);
    chk("div9.S0", 32'(S_out0), 0);
    tick(1);
    chk("div10.S0", 32'(S_out0), 1);

    // Alarm at 10:20, clock at 10:19:01 with divider at 0.
    AL_ON = 1'b1;
    set_in(2'd1, 4'd0, 4'd2, 4'd0);
    LD_alarm = 1'b1;
    tick(1);
    LD_alarm = 1'b0;
    chk_time("ldal", 1, 0, 1, 9, 0, 1);
    tick(588);
    chk_time("pre", 1, 0, 1, 9, 5, 9);
    tick(1);
    chk_time("hit", 1, 0, 2, 0, 0, 0);
    chk("hit.alarm", 32'(Alarm), 0);
    tick(1);
    chk("rise.alarm", 32'(Alarm), 1);
    tick(30);
    chk("sticky.alarm", 32'(Alarm), 1);
    STOP_al = 1'b1;
    tick(1);
    chk("stop.alarm", 32'(Alarm), 0);
    STOP_al = 1'b0;
    tick(50);
    chk("stopheld.alarm", 32'(Alarm), 0);

    // Load time equal to alarm: flag rises the edge after the load.
    LD_time = 1'b1;
    tick(1);
    LD_time = 1'b0;
    chk_time("ldeq", 1, 0, 2, 0, 0, 0);
    chk("ldeq.alarm", 32'(Alarm), 0);
    tick(1);
    chk("ldeq1.alarm", 32'(Alarm), 1);
    AL_ON = 1'b0;
    tick(1);
    chk("aloff.alarm", 32'(Alarm), 0);

    // Disabled alarm ignores a match.
    LD_time = 1'b1;
    tick(1);
    LD_time = 1'b0;
    tick(6);
    chk("dis.alarm", 32'(Alarm), 0);

    // Set condition with STOP_al held through the whole matching second.
    AL_ON = 1'b1;
    STOP_al = 1'b1;
    LD_time = 1'b1;
    tick(1);
    LD_time = 1'b0;
    tick(1);
    chk("stopset.alarm", 32'(Alarm), 0);
    tick(15);
    chk("stopset2.alarm", 32'(Alarm), 0);
    STOP_al = 1'b0;
    tick(2);
    chk("stopset3.alarm", 32'(Alarm), 0);

    // Hold LD_time for 30 cycles at 23:59, then roll over midnight.
    set_in(2'd2, 4'd3, 4'd5, 4'd9);
    LD_time = 1'b1;
    tick(30);
    chk_time("hold", 2, 3, 5, 9, 0, 0);
    LD_time = 1'b0;
    tick(9);
    chk("hold9.S0", 32'(S_out0), 0);
    tick(1);
    chk("hold10.S0", 32'(S_out0), 1);
    tick(580);
    chk_time("2359", 2, 3, 5, 9, 5, 9);
    tick(9);
    chk("2359b.S0", 32'(S_out0), 9);
    tick(1);
    chk_time("midn", 0, 0, 0, 0, 0, 0);

    // Illegal 27:75 loads unchecked and recovers on the next minute carry.
    set_in(2'd2, 4'd7, 4'd7, 4'd5);
    LD_time = 1'b1;
    tick(1);
    LD_time = 1'b0;
    chk_time("bad", 2, 7, 7, 5, 0, 0);
    tick(590);
    chk_time("bad59", 2, 7, 7, 5, 5, 9);
    tick(10);
    chk_time("badwrap", 0, 0, 0, 0, 0, 0);

    // Async reset mid-second while the alarm is high.
    set_in(2'd1, 4'd0, 4'd2, 4'd0);
    LD_time = 1'b1;
    tick(1);
    LD_time = 1'b0;
    tick(1);
    chk("pre_rst.alarm", 32'(Alarm), 1);
    set_in(2'd1, 4'd2, 4'd3, 4'd4);
    #2;
    reset = 1'b1;
    #1;
    chk_time("arst", 1, 2, 3, 4, 0, 0);
    chk("arst.alarm", 32'(Alarm), 0);
    tick(1);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
